// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// The requester drives the master side; the unit implements the slave side.
interface alu_muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_op, funct, src_a, src_b,
        input  busy, done, div_by_zero, stall, result, hi, lo
    );

    modport slave (
        input  start, alu_op, funct, src_a, src_b,
        output busy, done, div_by_zero, stall, result, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide,
// one bit per cycle, with mfhi/mflo/mthi/mtlo access to HI/LO.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    alu_muldiv_seq_if.slave  bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W2-1:0]   p_q;
    logic [WIDTH-1:0] b_q;
    logic            is_div_q, neg_q_q, neg_r_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic            busy_q, done_q, dbz_pulse_q;

    // Instruction decode; only alu_op = 2'b10 selects this unit.
    logic act;
    logic dec_mult, dec_multu, dec_div, dec_divu;
    logic dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
    logic dec_md, dec_any;

    assign act       = (bus.alu_op == 2'b10);
    assign dec_mult  = act && (bus.funct == 6'b011000);
    assign dec_multu = act && (bus.funct == 6'b011001);
    assign dec_div   = act && (bus.funct == 6'b011010);
    assign dec_divu  = act && (bus.funct == 6'b011011);
    assign dec_mfhi  = act && (bus.funct == 6'b010000);
    assign dec_mflo  = act && (bus.funct == 6'b010010);
    assign dec_mthi  = act && (bus.funct == 6'b010001);
    assign dec_mtlo  = act && (bus.funct == 6'b010011);
    assign dec_md    = dec_mult || dec_multu || dec_div || dec_divu;
    assign dec_any   = dec_md || dec_mfhi || dec_mflo || dec_mthi || dec_mtlo;

    logic             idle, go_md, go_zero, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign idle      = (state_q == S_IDLE);
    assign go_md     = bus.start && idle && dec_md;
    assign op_div    = dec_div || dec_divu;
    assign go_zero   = go_md && op_div && (bus.src_b == '0);
    assign op_signed = SIGNED_EN && (dec_mult || dec_div);
    assign a_neg     = op_signed && bus.src_a[WIDTH-1];
    assign b_neg     = op_signed && bus.src_b[WIDTH-1];
    assign a_abs     = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs     = b_neg ? -bus.src_b : bus.src_b;

    // One iteration: p_q holds {acc/remainder, multiplier/quotient}.
    logic [WIDTH:0]  add_sum, div_shift, div_trial;
    logic [W2-1:0]   step_d;

    assign add_sum   = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign step_d    = !is_div_q    ? {add_sum, p_q[WIDTH-1:1]} :
                       div_trial[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0} :
                                          {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    // Sign correction applied while in FIX.
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    assign prod_fix = neg_q_q ? -p_q : p_q;

    always_comb begin
        fin_hi = p_q[W2-1:WIDTH];
        fin_lo = p_q[WIDTH-1:0];
        if (!dbz_q) begin
            if (is_div_q) begin
                fin_lo = neg_q_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                fin_hi = neg_r_q ? -p_q[W2-1:WIDTH] : p_q[W2-1:WIDTH];
            end else begin
                fin_hi = prod_fix[W2-1:WIDTH];
                fin_lo = prod_fix[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // The final RUN cycle (counter = WIDTH) retires the counter and hands off to FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_md) state_d = go_zero ? S_FIX : S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            p_q         <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIX);
            dbz_pulse_q <= go_zero;
            case (state_q)
                S_IDLE: begin
                    if (go_md) begin
                        cnt_q    <= '0;
                        b_q      <= b_abs;
                        is_div_q <= op_div;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        dbz_q    <= go_zero;
                        p_q      <= go_zero ? {bus.src_a, {WIDTH{1'b1}}}
                                            : {{WIDTH{1'b0}}, a_abs};
                    end else if (bus.start && dec_mthi) begin
                        hi_q <= bus.src_a;
                    end else if (bus.start && dec_mtlo) begin
                        lo_q <= bus.src_a;
                    end
                end
                S_RUN: begin
                    if (cnt_q != CW'(WIDTH)) begin
                        p_q   <= step_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_pulse_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.stall       = bus.start && dec_any && busy_q;
    assign bus.result      = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq (WIDTH=32): directed mult/div vectors,
// HI/LO moves, stall behaviour and mid-operation reset.
module tb_alu_muldiv_seq;
    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   outstanding = 0;
    exp_t sb[$];

    alu_muldiv_seq_if #(.WIDTH(W)) bus ();

    alu_muldiv_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one mult/div and record its expected completion.
    task automatic issue_md(input string name, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edbz);
        exp_t e;
        int   guard = 0;
        while (bus.busy === 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", 1, 0);
        bus.alu_op = 2'b10;
        bus.funct  = f;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.start  = 1'b1;
        e.name     = name;
        e.hi       = ehi;
        e.lo       = elo;
        e.dbz      = edbz;
        e.done_cyc = cyc + 1 + (edbz ? 0 : W + 1);
        sb.push_back(e);
        outstanding++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (outstanding != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("done_timeout", 1, 0);
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks HI/LO one edge later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
                    @(negedge clk);
                    chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                    chk({e.name, "_busy_low"}, 64'(bus.busy), 64'(0));
                    outstanding--;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct  = 6'b0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_dbz",  64'(bus.div_by_zero), 0);
        chk("rst_hi",   64'(bus.hi), 0);
        chk("rst_lo",   64'(bus.lo), 0);

        // Start on the very first edge after reset release.
        reset = 1'b0;
        issue_md("mult_m3x7", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        wait_idle();
        issue_md("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_idle();
        issue_md("div_m7d2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_idle();
        issue_md("divu_7d0", F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        issue_md("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        wait_idle();
        issue_md("divu_100d7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_idle();
        issue_md("mult_min2", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        wait_idle();
        issue_md("div_7dm2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        wait_idle();
        issue_md("div_0d0", F_DIV, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        issue_md("multu_sh", F_MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0);
        wait_idle();
        issue_md("div_m8dm3", F_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2, 1'b0);
        wait_idle();

        // mthi / mtlo / mfhi / mflo in IDLE.
        @(negedge clk);
        bus.alu_op = 2'b10; bus.funct = F_MTHI; bus.src_a = 32'h1234; bus.start = 1'b1;
        @(negedge clk);
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        chk("mthi_no_done", 64'(bus.done), 0);
        bus.funct = F_MTLO; bus.src_a = 32'h5678;
        @(negedge clk);
        chk("mtlo_lo", 64'(bus.lo), 64'h5678);
        chk("mtlo_hi_kept", 64'(bus.hi), 64'h1234);
        bus.funct = F_MFHI; #1;
        chk("mfhi_result", 64'(bus.result), 64'h1234);
        chk("mfhi_no_stall", 64'(bus.stall), 0);
        bus.funct = F_MFLO; #1;
        chk("mflo_result", 64'(bus.result), 64'h5678);
        bus.funct = 6'b100000; #1;
        chk("other_result", 64'(bus.result), 0);
        bus.alu_op = 2'b00; bus.funct = F_MFHI; #1;
        chk("aluop_result", 64'(bus.result), 0);
        @(negedge clk);
        chk("nop_busy", 64'(bus.busy), 0);
        bus.start = 1'b0;

        // mflo five cycles after a mult start: stalls through the done cycle.
        issue_md("mult_5x6", F_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_mid", 64'(bus.busy), 1);
        bus.alu_op = 2'b10; bus.funct = F_MFLO; bus.start = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.stall !== 1'b1) break;
            stall_cnt++;
            @(negedge clk);
        end
        chk("mflo_stall_cycles", 64'(stall_cnt), 64'(W - 2));
        chk("mflo_new_lo", 64'(bus.result), 64'd30);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset mid-RUN aborts without done; start alongside reset is ignored.
        bus.alu_op = 2'b10; bus.funct = F_MULT; bus.src_a = 32'd9; bus.src_b = 32'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 1);
        reset = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 0);
        chk("abort_hi", 64'(bus.hi), 0);
        chk("abort_lo", 64'(bus.lo), 0);
        chk("abort_done", 64'(bus.done), 0);
        reset = 1'b0;
        issue_md("mult_after_rst", F_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
